winograd_f23_pipe: RTL and testbench

//  Pipelined, streaming Winograd F(2x2,3x3) convolution engine; successor to the combinational single-tile block.
//  Per beat: one 4x4 input tile + one 3x3 kernel (one input channel). Beats are accumulated in the transform domain across channels.

---
 rtl/winograd_pkg.sv | 32 +++
 rtl/winograd_in_xform.sv | 42 ++++
 rtl/winograd_f23_pipe.sv | 174 +++++++++++++++++
 tb/tb_winograd_f23_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared Winograd F(2x2,3x3) coefficients, width growth constants and the output clamp.
package winograd_pkg;

    // B^T, the doubled kernel transform 2G, and A^T
    localparam int BT [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
    localparam int G2 [4][3] = '{'{2, 0, 0}, '{1, 1, 1}, '{1, -1, 1}, '{0, 0, 2}};
    localparam int AT [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

    // Bit growth over DATA_W for V, U' and P
    localparam int V_GROW = 2;
    localparam int U_GROW = 4;
    localparam int P_GROW = 6;

    // Clamp x to a w-bit signed range; flag reports whether clamping occurred.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w,
                                               output logic flag);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        flag = 1'b0;
        if (x > hi) begin
            flag = 1'b1;
            return hi;
        end
        if (x < lo) begin
            flag = 1'b1;
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/winograd_in_xform.sv
// Combinational input-tile transform V = B^T d B on a 4x4 signed tile.
module winograd_in_xform
    import winograd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [16*DATA_W-1:0]          tile,
    output logic [16*(DATA_W+V_GROW)-1:0] v
);

    localparam int W = DATA_W + V_GROW;

    logic signed [W-1:0] d [4][4];
    logic signed [W-1:0] t [4][4];
    logic signed [W-1:0] y [4][4];

    function automatic logic signed [W-1:0] vmac(input logic signed [W-1:0] a, input int c,
                                                 input logic signed [W-1:0] x);
        if (c == 1)  return a + x;
        if (c == -1) return a - x;
        return a;
    endfunction

    always_comb begin
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                d[r][c] = W'(signed'(tile[(r*4+c)*DATA_W +: DATA_W]));
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) begin
                t[i][c] = '0;
                for (int k = 0; k < 4; k++) t[i][c] = vmac(t[i][c], BT[i][k], d[k][c]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                y[i][j] = '0;
                for (int k = 0; k < 4; k++) y[i][j] = vmac(y[i][j], BT[j][k], t[i][k]);
                v[(i*4+j)*W +: W] = y[i][j];
            end
    end

endmodule

// File: rtl/winograd_f23_pipe.sv
// Streaming Winograd F(2x2,3x3) engine: S1 transforms, S2 multiply, S3 accumulate, S4 output.
// Define WINO_RELU_EN to zero negative outputs after saturation.
module winograd_f23_pipe
    import winograd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int CH_MAX = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [16*DATA_W-1:0]         in_tile,
    input  logic [9*DATA_W-1:0]          in_kern,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*OUT_W-1:0]           out_tile,
    output logic [3:0]                   out_sat,
    output logic [$clog2(CH_MAX+1)-1:0]  out_ch_cnt,
    output logic                         out_forced
);

    localparam int CW     = $clog2(CH_MAX + 1);
    localparam int VW     = DATA_W + V_GROW;
    localparam int UW     = DATA_W + U_GROW;
    localparam int PW     = 2 * DATA_W + P_GROW;
    localparam int YW     = ACC_W + 2;
    localparam int STAGES = 2;

    logic en, first, close, hit_max;
    logic [CW-1:0] ch_cnt;
    logic [STAGES:0] vld_pipe, first_p, last_p, forced_p;
    logic [STAGES:0][CW-1:0] cnt_p;

    logic [16*VW-1:0] v_c, v_q;
    logic [15:0][UW-1:0] u_c, u_q;
    logic [15:0][ACC_W-1:0] p_c, p_q, m;
    logic signed [UW-1:0] g [3][3];
    logic signed [UW-1:0] tk [4][3];
    logic signed [YW-1:0] me [4][4];
    logic signed [YW-1:0] t2 [2][4];
    logic [4*OUT_W-1:0] tile_c;
    logic [3:0] sat_c;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign hit_max  = (ch_cnt == CW'(CH_MAX - 1));
    assign close    = in_last || hit_max;

    function automatic logic signed [UW-1:0] umac(input logic signed [UW-1:0] a, input int c,
                                                  input logic signed [UW-1:0] x);
        if (c == 2)  return a + (x <<< 1);
        if (c == 1)  return a + x;
        if (c == -1) return a - x;
        return a;
    endfunction

    function automatic logic signed [YW-1:0] ymac(input logic signed [YW-1:0] a, input int c,
                                                  input logic signed [YW-1:0] x);
        if (c == 1)  return a + x;
        if (c == -1) return a - x;
        return a;
    endfunction

    winograd_in_xform #(.DATA_W(DATA_W)) u_in_xform (.tile(in_tile), .v(v_c));

    // Kernel transform with 2G keeps everything integer; the extra 4x is removed after A^T M A.
    always_comb begin
        logic signed [UW-1:0] uu;
        u_c = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[r][c] = UW'(signed'(in_kern[(r*3+c)*DATA_W +: DATA_W]));
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) begin
                tk[i][c] = '0;
                for (int k = 0; k < 3; k++) tk[i][c] = umac(tk[i][c], G2[i][k], g[k][c]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                uu = '0;
                for (int k = 0; k < 3; k++) uu = umac(uu, G2[j][k], tk[i][k]);
                u_c[i*4+j] = uu;
            end
    end

    always_comb begin
        logic signed [PW-1:0] ue, ve, pr;
        p_c = '0;
        for (int k = 0; k < 16; k++) begin
            ue = PW'(signed'(u_q[k]));
            ve = PW'(signed'(v_q[k*VW +: VW]));
            pr = ue * ve;
            p_c[k] = ACC_W'(pr);
        end
    end

    always_comb begin
        logic signed [YW-1:0] yy;
        logic signed [OUT_W-1:0] ov;
        logic f;
        tile_c = '0;
        sat_c  = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                me[r][c] = YW'(signed'(m[r*4+c]));
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                t2[i][c] = '0;
                for (int k = 0; k < 4; k++) t2[i][c] = ymac(t2[i][c], AT[i][k], me[k][c]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                yy = '0;
                for (int k = 0; k < 4; k++) yy = ymac(yy, AT[j][k], t2[i][k]);
                ov = OUT_W'(sat(64'(yy >>> 2), OUT_W, f));
`ifdef WINO_RELU_EN
                if (ov[OUT_W-1]) ov = '0;
`endif
                tile_c[(i*2+j)*OUT_W +: OUT_W] = ov;
                sat_c[i*2+j] = f;
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_p    <= '0;
            last_p     <= '0;
            forced_p   <= '0;
            cnt_p      <= '0;
            first      <= 1'b1;
            ch_cnt     <= '0;
            out_valid  <= 1'b0;
            out_tile   <= '0;
            out_sat    <= '0;
            out_ch_cnt <= '0;
            out_forced <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            first_p  <= {first_p[STAGES-1:0], first};
            last_p   <= {last_p[STAGES-1:0], close};
            forced_p <= {forced_p[STAGES-1:0], hit_max && !in_last};
            cnt_p    <= {cnt_p[STAGES-1:0], ch_cnt + CW'(1)};
            if (in_valid) begin
                first  <= close;
                ch_cnt <= close ? '0 : ch_cnt + CW'(1);
            end
            out_valid <= vld_pipe[STAGES] && last_p[STAGES];
            if (vld_pipe[STAGES] && last_p[STAGES]) begin
                out_tile   <= tile_c;
                out_sat    <= sat_c;
                out_ch_cnt <= cnt_p[STAGES];
                out_forced <= forced_p[STAGES];
            end
        end
    end

    // Datapath registers need no reset: validity and the first-beat tag gate their use.
    always_ff @(posedge clk) begin
        if (en) begin
            v_q <= v_c;
            u_q <= u_c;
            p_q <= p_c;
            if (vld_pipe[1])
                for (int k = 0; k < 16; k++)
                    m[k] <= first_p[1] ? p_q[k] : m[k] + p_q[k];
        end
    end

endmodule

// File: tb/tb_winograd_f23_pipe.sv
// Directed bench for winograd_f23_pipe with hand-computed output tiles (CH_MAX reduced to 4).
module tb_winograd_f23_pipe;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_last, out_ready;
    logic         in_ready, out_valid, out_forced;
    logic [127:0] in_tile;
    logic [71:0]  in_kern;
    logic [31:0]  out_tile;
    logic [3:0]   out_sat;
    logic [2:0]   out_ch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    winograd_f23_pipe #(.DATA_W(8), .OUT_W(8), .ACC_W(32), .CH_MAX(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tile(in_tile), .in_kern(in_kern), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile),
        .out_sat(out_sat), .out_ch_cnt(out_ch_cnt), .out_forced(out_forced)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] t_ramp();
        logic [127:0] t;
        for (int i = 0; i < 16; i++) t[i*8 +: 8] = 8'(i);
        return t;
    endfunction

    function automatic logic [127:0] t_const(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [71:0] k_const(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] k_center(input logic [7:0] v);
        logic [71:0] k;
        k = '0;
        k[4*8 +: 8] = v;
        return k;
    endfunction

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic beat(input logic [127:0] t, input logic [71:0] k, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_tile = t; in_kern = k; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] et, input logic [3:0] es,
                             input logic [2:0] ec, input logic ef);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_tile"}, out_tile, et);
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
        chk({tag, "_cnt"}, 32'(out_ch_cnt), 32'(ec));
        chk({tag, "_forced"}, 32'(out_forced), 32'(ef));
    endtask

    task automatic get_out(input string tag, input logic [31:0] et, input logic [3:0] es,
                           input logic [2:0] ec, input logic ef);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_out(tag, et, es, ec, ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_tile = '0; in_kern = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_tile", out_tile, 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_cnt", 32'(out_ch_cnt), 32'd0);
        chk("rst_forced", 32'(out_forced), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // single channel, centre tap: output is the tile's inner 2x2, 3-edge latency
        beat(t_ramp(), k_center(8'd1), 1'b1);
        @(negedge clk) chk("lat_t0", 32'(out_valid), 32'd0);
        @(negedge clk) chk("lat_t1", 32'(out_valid), 32'd0);
        @(negedge clk) chk("lat_t2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_out("t1", pk(5, 6, 9, 10), 4'h0, 3'd1, 1'b0);

        beat(t_const(8'd2), k_const(8'd1), 1'b1);
        get_out("t2", pk(18, 18, 18, 18), 4'h0, 3'd1, 1'b0);

        beat(t_ramp(), k_center(8'd1), 1'b0);
        beat(t_const(8'd1), k_const(8'd1), 1'b1);
        get_out("t3", pk(14, 15, 18, 19), 4'h0, 3'd2, 1'b0);

        beat(t_const(8'd127), k_const(8'd127), 1'b1);
        get_out("sat_hi", pk(127, 127, 127, 127), 4'hF, 3'd1, 1'b0);

        beat(t_const(8'd127), k_const(8'h80), 1'b1);
`ifdef WINO_RELU_EN
        get_out("sat_lo", pk(0, 0, 0, 0), 4'hF, 3'd1, 1'b0);
`else
        get_out("sat_lo", pk(-128, -128, -128, -128), 4'hF, 3'd1, 1'b0);
`endif

        beat(t_ramp(), k_center(8'hFF), 1'b1);
`ifdef WINO_RELU_EN
        get_out("neg", pk(0, 0, 0, 0), 4'h0, 3'd1, 1'b0);
`else
        get_out("neg", pk(-5, -6, -9, -10), 4'h0, 3'd1, 1'b0);
`endif

        // back-pressure: three groups queue up behind a held output
        @(negedge clk) out_ready = 1'b0;
        beat(t_ramp(), k_center(8'd1), 1'b1);
        beat(t_const(8'd2), k_const(8'd1), 1'b1);
        beat(t_const(8'd1), k_const(8'd1), 1'b1);
        repeat (5) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        check_out("stall_a", pk(5, 6, 9, 10), 4'h0, 3'd1, 1'b0);
        out_ready = 1'b1;
        get_out("stall_b", pk(18, 18, 18, 18), 4'h0, 3'd1, 1'b0);
        get_out("stall_c", pk(9, 9, 9, 9), 4'h0, 3'd1, 1'b0);
        @(negedge clk) chk("stall_drain", 32'(out_valid), 32'd0);

        // reset in the middle of a two-beat group discards it
        beat(t_const(8'd3), k_const(8'd3), 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        beat(t_ramp(), k_center(8'd1), 1'b1);
        get_out("rst_mid", pk(5, 6, 9, 10), 4'h0, 3'd1, 1'b0);
        repeat (6) @(negedge clk);
        chk("rst_mid_nodup", 32'(out_valid), 32'd0);

        // CH_MAX=4 forces a close on the fourth beat; the fifth starts a new group
        for (int i = 0; i < 4; i++) beat(t_ramp(), k_center(8'd1), 1'b0);
        beat(t_const(8'd2), k_const(8'd1), 1'b1);
        get_out("forced", pk(20, 24, 36, 40), 4'h0, 3'd4, 1'b1);
        get_out("after_forced", pk(18, 18, 18, 18), 4'h0, 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
